mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 27 ++
 rtl/mem_access_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// Bus bundle between a CPU-side requester, the memory access unit and a data memory.
interface mem_access_unit_if #(parameter int ADDR_W = 10);
   logic              req;
   logic              we;
   logic [1:0]        size;
   logic              sign_ext;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic              ready;
   logic              done;
   logic [31:0]       rdata;
   logic              err;
   logic              mem_WE;
   logic [31:0]       mem_WD;
   logic [ADDR_W-1:0] mem_Address;
   logic [31:0]       mem_RD;

   modport slave (
      input  req, we, size, sign_ext, addr, wdata, mem_RD,
      output ready, done, rdata, err, mem_WE, mem_WD, mem_Address
   );

   modport master (
      output req, we, size, sign_ext, addr, wdata, mem_RD,
      input  ready, done, rdata, err, mem_WE, mem_WD, mem_Address
   );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/halfword/word load-store unit over a word-wide memory; sub-word stores use read-merge-write.
// Optional misalignment trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_unit #(parameter int ADDR_W = 10) (
   input logic             clk,
   input logic             rst_n,
   mem_access_unit_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

   state_t            state_r, state_s;
   logic              we_r, sign_r, mis_r, mis_s, cap_s;
   logic [1:0]        size_r;
   logic [1:0]        off_r;
   logic [31:0]       wdata_r;
   logic              ready_r, ready_s, done_r, done_s, err_r, err_s, mem_we_r, mem_we_s;
   logic [31:0]       rdata_r, rdata_s, mem_wd_r, mem_wd_s;
   logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;

   function automatic logic [31:0] load_ext(input logic [31:0] rd, input logic [1:0] sz,
                                            input logic [1:0] off, input logic sx);
      logic [7:0]  b;
      logic [15:0] h;
      b = rd[{off, 3'b000} +: 8];
      h = rd[{off[1], 4'b0000} +: 16];
      case (sz)
         2'b00:   load_ext = {{24{sx & b[7]}}, b};
         2'b01:   load_ext = {{16{sx & h[15]}}, h};
         default: load_ext = rd;
      endcase
   endfunction

   function automatic logic [31:0] merge_lane(input logic [31:0] rd, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] off);
      logic [31:0] r;
      r = rd;
      case (sz)
         2'b00:   r[{off, 3'b000} +: 8]    = wd[7:0];
         2'b01:   r[{off[1], 4'b0000} +: 16] = wd[15:0];
         default: r = wd;
      endcase
      return r;
   endfunction

`ifdef MEM_MISALIGN_TRAP_EN
   assign mis_s = ((bus.size == 2'b01) & bus.addr[0]) | (bus.size[1] & (bus.addr[1:0] != 2'b00));
`else
   assign mis_s = 1'b0;
`endif

   // Next state and next values of every registered output
   always_comb begin
      state_s    = state_r;
      cap_s      = 1'b0;
      ready_s    = 1'b0;
      done_s     = 1'b0;
      mem_we_s   = 1'b0;
      mem_wd_s   = 32'h0000_0000;
      mem_addr_s = '0;
      rdata_s    = rdata_r;
      err_s      = err_r;
      case (state_r)
         IDLE: begin
            if (bus.req && ready_r) begin
               state_s    = ACCESS;
               cap_s      = 1'b1;
               err_s      = 1'b0;
               mem_addr_s = {bus.addr[ADDR_W-1:2], 2'b00};
               if (bus.we && bus.size[1] && !mis_s) begin
                  mem_we_s = 1'b1;
                  mem_wd_s = bus.wdata;
               end else begin
                  mem_we_s = 1'b0;
               end
            end else begin
               ready_s = 1'b1;
            end
         end
         ACCESS: begin
            if (mis_r) begin
               state_s = RESP;
               done_s  = 1'b1;
               err_s   = 1'b1;
            end else if (we_r && !size_r[1]) begin
               // Merged word is built from the read data sampled now and written in MERGE
               state_s    = MERGE;
               mem_we_s   = 1'b1;
               mem_addr_s = mem_addr_r;
               mem_wd_s   = merge_lane(bus.mem_RD, wdata_r, size_r, off_r);
            end else begin
               state_s = RESP;
               done_s  = 1'b1;
               if (!we_r) begin
                  rdata_s = load_ext(bus.mem_RD, size_r, off_r, sign_r);
               end else begin
                  rdata_s = rdata_r;
               end
            end
         end
         MERGE: begin
            state_s = RESP;
            done_s  = 1'b1;
         end
         RESP: begin
            state_s = IDLE;
            ready_s = 1'b1;
         end
         default: begin
            state_s = IDLE;
            ready_s = 1'b1;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         ready_r    <= 1'b1;
         done_r     <= 1'b0;
         rdata_r    <= 32'h0000_0000;
         err_r      <= 1'b0;
         mem_we_r   <= 1'b0;
         mem_wd_r   <= 32'h0000_0000;
         mem_addr_r <= '0;
      end else begin
         state_r    <= state_s;
         ready_r    <= ready_s;
         done_r     <= done_s;
         rdata_r    <= rdata_s;
         err_r      <= err_s;
         mem_we_r   <= mem_we_s;
         mem_wd_r   <= mem_wd_s;
         mem_addr_r <= mem_addr_s;
      end
   end

   // Request capture at acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_r    <= 1'b0;
         sign_r  <= 1'b0;
         mis_r   <= 1'b0;
         size_r  <= 2'b00;
         off_r   <= 2'b00;
         wdata_r <= 32'h0000_0000;
      end else if (cap_s) begin
         we_r    <= bus.we;
         sign_r  <= bus.sign_ext;
         mis_r   <= mis_s;
         size_r  <= bus.size;
         off_r   <= bus.addr[1:0];
         wdata_r <= bus.wdata;
      end
   end

   assign bus.ready       = ready_r;
   assign bus.done        = done_r;
   assign bus.rdata       = rdata_r;
   assign bus.mem_WE      = mem_we_r;
   assign bus.mem_WD      = mem_wd_r;
   assign bus.mem_Address = mem_addr_r;
`ifdef MEM_MISALIGN_TRAP_EN
   assign bus.err         = err_r;
`else
   assign bus.err         = 1'b0;
`endif
endmodule
